// File: rtl/array_bank_sched.sv
// Frame router and round-robin bank refresh scheduler for the array engines.
// Optional watchdog on WR/RD/RF dwell time is enabled by defining ARRAY_SCHED_TIMEOUT_EN.
module array_bank_sched #(
  parameter int BANK_NUM        = 4,
  parameter int BANK_ID_WIDTH   = 2,
  parameter int COL_ADDR_WIDTH  = 6,
  parameter int ROW_ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int FRAME_WIDTH     = 3 + COL_ADDR_WIDTH + ROW_ADDR_WIDTH + DATA_WIDTH,
  parameter int RF_CNT_WIDTH    = 25,
  parameter int RF_POSTPONE_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mc_en,
  input  logic                     in_frame_valid,
  input  logic [FRAME_WIDTH-1:0]   in_frame_data,
  output logic                     in_frame_ready,
  output logic                     array_wframe_valid,
  output logic [FRAME_WIDTH-1:0]   array_wframe_data,
  input  logic                     array_wframe_ready,
  output logic                     array_wr_start,
  input  logic                     array_wr_done,
  output logic                     array_rframe_valid,
  output logic [FRAME_WIDTH-1:0]   array_rframe_data,
  input  logic                     array_rframe_ready,
  output logic                     array_rd_start,
  input  logic                     array_rd_done,
  input  logic                     array_rf_period_sel,
  input  logic [RF_CNT_WIDTH-1:0]  array_rf_period_0,
  input  logic [RF_CNT_WIDTH-1:0]  array_rf_period_1,
  output logic                     array_rf_start,
  output logic [BANK_ID_WIDTH-1:0] array_rf_bank,
  input  logic                     array_rf_done,
  output logic [1:0]               array_mux_sel,
  output logic [3:0]               rf_pending,
  output logic                     rf_overflow,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RF = 2'd3} state_t;

  localparam logic [3:0]               PEND_MAX  = 4'(RF_POSTPONE_MAX);
  localparam logic [BANK_ID_WIDTH-1:0] BANK_LAST = BANK_ID_WIDTH'(BANK_NUM - 1);

  state_t                   state_r;
  logic [RF_CNT_WIDTH-1:0]  rf_cnt_r;
  logic [RF_CNT_WIDTH-1:0]  period_s;
  logic [3:0]               pending_r;
  logic                     overflow_r;
  logic [BANK_ID_WIDTH-1:0] bank_r;
  logic                     wr_start_r;
  logic                     rd_start_r;
  logic                     rf_start_r;
  logic                     tick_s;
  logic                     sof_s;
  logic                     rw_s;
  logic                     done_s;
  logic                     exit_s;
  logic                     rf_dec_s;
  logic                     wd_fire_s;

  assign sof_s    = in_frame_data[FRAME_WIDTH-2];
  assign rw_s     = in_frame_data[FRAME_WIDTH-3];
  assign period_s = array_rf_period_sel ? array_rf_period_0 : array_rf_period_1;
  // >= rather than == so that shrinking the period below the live count wraps at once
  assign tick_s   = mc_en & (rf_cnt_r >= period_s);
  assign exit_s   = done_s | wd_fire_s;
  assign rf_dec_s = (state_r == RF) & exit_s;

  // Done pulse belonging to the operation currently in progress
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      WR:      done_s = array_wr_done;
      RD:      done_s = array_rd_done;
      RF:      done_s = array_rf_done;
      default: done_s = 1'b0;
    endcase
  end

`ifdef ARRAY_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_r;

  assign wd_fire_s   = (state_r != IDLE) & (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_r;

  // Dwell-time counter, cleared whenever the FSM rests in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r  <= '0;
      timeout_r <= 1'b0;
    end else begin
      wd_cnt_r <= (state_r == IDLE) ? '0 : wd_cnt_r + WD_W'(1);
      if (wd_fire_s && !done_s) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  assign wd_fire_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Refresh period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_cnt_r <= '0;
    end else if (!mc_en || tick_s) begin
      rf_cnt_r <= '0;
    end else begin
      rf_cnt_r <= rf_cnt_r + RF_CNT_WIDTH'(1);
    end
  end

  // Outstanding refresh accounting; tick and completion together cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r  <= 4'd0;
      overflow_r <= 1'b0;
    end else if (!mc_en) begin
      pending_r  <= 4'd0;
      overflow_r <= 1'b0;
    end else begin
      if (tick_s && pending_r == PEND_MAX) begin
        overflow_r <= 1'b1;
      end
      if (tick_s && !rf_dec_s && pending_r != PEND_MAX) begin
        pending_r <= pending_r + 4'd1;
      end else if (!tick_s && rf_dec_s && pending_r != 4'd0) begin
        pending_r <= pending_r - 4'd1;
      end
    end
  end

  // Scheduler FSM with registered start pulses and bank rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_start_r <= 1'b0;
      rd_start_r <= 1'b0;
      rf_start_r <= 1'b0;
      bank_r     <= '0;
    end else begin
      wr_start_r <= 1'b0;
      rd_start_r <= 1'b0;
      rf_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mc_en) begin
            if (pending_r == PEND_MAX) begin
              state_r    <= RF;
              rf_start_r <= 1'b1;
            end else if (in_frame_valid && sof_s) begin
              state_r    <= rw_s ? WR : RD;
              wr_start_r <= rw_s;
              rd_start_r <= ~rw_s;
            end else if (pending_r != 4'd0) begin
              state_r    <= RF;
              rf_start_r <= 1'b1;
            end
          end
        end
        WR, RD: begin
          if (exit_s) begin
            state_r <= IDLE;
          end
        end
        RF: begin
          if (exit_s) begin
            state_r <= IDLE;
            bank_r  <= (bank_r == BANK_LAST) ? '0 : bank_r + BANK_ID_WIDTH'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Zero-latency frame steering; non-SOF beats offered in IDLE are swallowed
  always_comb begin
    array_wframe_valid = 1'b0;
    array_wframe_data  = '0;
    array_rframe_valid = 1'b0;
    array_rframe_data  = '0;
    in_frame_ready     = 1'b0;
    case (state_r)
      WR: begin
        array_wframe_valid = in_frame_valid;
        array_wframe_data  = in_frame_data;
        in_frame_ready     = array_wframe_ready;
      end
      RD: begin
        array_rframe_valid = in_frame_valid;
        array_rframe_data  = in_frame_data;
        in_frame_ready     = array_rframe_ready;
      end
      IDLE:    in_frame_ready = in_frame_valid & ~sof_s;
      default: in_frame_ready = 1'b0;
    endcase
  end

  assign array_mux_sel  = state_r;
  assign array_wr_start = wr_start_r;
  assign array_rd_start = rd_start_r;
  assign array_rf_start = rf_start_r;
  assign array_rf_bank  = bank_r;
  assign rf_pending     = pending_r;
  assign rf_overflow    = overflow_r;

endmodule

// File: doc/array_bank_sched.md
Name: array_bank_sched

Overview:
Multi-bank successor to the array state controller. It sits between the AXI-side internal frame stream and the array write, read and refresh engines. It routes each SOF-delimited frame to the write or read engine and schedules per-bank refresh in round-robin order. Refresh requests are accumulated and may be postponed up to a bound, which the single-bank controller could not do.

Parameters:
BANK_NUM, 4, number of array banks refreshed in rotation (power of 2, >=2)
BANK_ID_WIDTH, 2, log2(BANK_NUM)
COL_ADDR_WIDTH, 6, frame column address width
ROW_ADDR_WIDTH, 16, frame row address width
DATA_WIDTH, 64, frame data width
FRAME_WIDTH, 3+COL_ADDR_WIDTH+ROW_ADDR_WIDTH+DATA_WIDTH, frame width
RF_CNT_WIDTH, 25, refresh period counter width
RF_POSTPONE_MAX, 4, max outstanding refresh requests (1..15)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mc_en  in  1  controller enable
in_frame_valid  in  1  internal frame valid
in_frame_data  in  FRAME_WIDTH  layout: [FW-1]=eof, [FW-2]=sof, [FW-3]=rw (1=write), then row, col, data (data at LSBs)
in_frame_ready  out  1  internal frame ready
array_wframe_valid / array_wframe_data / array_wframe_ready  out/out/in  1/FRAME_WIDTH/1  write engine stream
array_wr_start  out  1  one-cycle write start pulse
array_wr_done  in  1  write engine done pulse
array_rframe_valid / array_rframe_data / array_rframe_ready  out/out/in  1/FRAME_WIDTH/1  read engine stream
array_rd_start  out  1  one-cycle read start pulse
array_rd_done  in  1  read engine done pulse
array_rf_period_sel  in  1  1 selects period_0, 0 selects period_1
array_rf_period_0  in  RF_CNT_WIDTH  refresh period A
array_rf_period_1  in  RF_CNT_WIDTH  refresh period B
array_rf_start  out  1  one-cycle refresh start pulse
array_rf_bank  out  BANK_ID_WIDTH  bank being refreshed
array_rf_done  in  1  refresh done pulse
array_mux_sel  out  2  current state encoding
rf_pending  out  4  outstanding refresh requests
rf_overflow  out  1  sticky: a tick arrived while pending==RF_POSTPONE_MAX
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: all outputs 0. FSM in IDLE, counters 0, array_rf_bank=0.
- States and array_mux_sel: IDLE=0, WR=1, RD=2, RF=3. array_mux_sel equals the registered state.
- Refresh counter:
  - Counts 0..period inclusive, then wraps to 0.
  - One-cycle tick when cnt==period (a tick every period+1 cycles; period=0 gives a tick every cycle).
  - Comparison uses cnt>=period, so a period change below the current count wraps on the next cycle.
  - mc_en=0 holds cnt=0.
- rf_pending:
  - +1 on tick, saturating at RF_POSTPONE_MAX; -1 on array_rf_done in RF.
  - Tick and done in the same cycle: value unchanged.
  - Tick while saturated: rf_overflow set.
  - mc_en=0 clears rf_pending and rf_overflow.
- IDLE decision, evaluated only when mc_en=1, in priority order:
  1. rf_pending==RF_POSTPONE_MAX: go to RF.
  2. in_frame_valid with sof=1: go to WR if rw=1, RD if rw=0.
  3. rf_pending>0: go to RF.
  4. Otherwise stay in IDLE.
- A valid frame without sof in IDLE is discarded: in_frame_ready=1 for that cycle. No error flag.
- Start pulses are registered: array_wr_start, array_rd_start or array_rf_start is high for exactly the first cycle in WR, RD or RF respectively.
- WR/RD data path (combinational, zero latency):
  - array_xframe_valid = in_frame_valid.
  - array_xframe_data = in_frame_data.
  - in_frame_ready = array_xframe_ready.
  - The inactive engine sees valid=0 and data=0. In IDLE and RF, in_frame_ready=0 (except the discard case above).
- Exits: WR leaves to IDLE on array_wr_done, RD on array_rd_done, RF on array_rf_done. The state returns to IDLE for at least one cycle between operations.
- On array_rf_done: array_rf_bank increments modulo BANK_NUM.
- mc_en dropping mid-operation: the current operation completes on its done pulse, then the FSM stays in IDLE. Done pulses seen in IDLE are ignored.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
ARRAY_SCHED_TIMEOUT_EN:
- Defined: a watchdog counts cycles in WR, RD and RF. If the count reaches TIMEOUT_CYCLES without the matching done pulse, the FSM is forced to IDLE and timeout_err is set (sticky until reset). In RF the bank still advances and rf_pending still decrements.
- Undefined: no watchdog; FSM waits for done indefinitely; timeout_err is tied to 0.

Test Plan:
- Period 9, sel=1, mc_en=1, no traffic -> array_rf_start every 10 cycles; array_rf_bank sequence 0,1,2,3,0; rf_pending returns to 0 after each done.
- Write frame with sof=1, rw=1 while pending=0 -> array_mux_sel=1, array_wr_start pulse on cycle 1; 4 beats pass with ready handshake; wr_done -> IDLE.
- Read frame held valid while ticks raise pending to 4 -> RF wins at pending==4 before RD; one more tick before rf_done -> rf_overflow=1, pending stays 4.
- Tick and rf_done in the same cycle with pending=2 -> pending stays 2; bank advances.
- mc_en deasserted during RD -> stays RD until rd_done, then IDLE; further sof frames are ignored; rf counter and pending are 0.
- With ARRAY_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold wr_done -> IDLE after 16 cycles, timeout_err=1; without the macro -> stays WR.
